ex_mem_skid_stage: RTL and testbench

Parametrised EX->MEM boundary stage for the pipelined rv32i core, replacing the plain stall/flush register with a valid/ready elastic stage. Holds up to two instructions in a main register and a skid register, so back-pressure from the data cache does not need a combinational in_ready path. From the main entry it generates the memory byte-enable, lane-shifted store data, strict-alignment fault, branch-taken flag and PC-mux select. It also keeps a saturating count of back-pressure cycles.

---
 rtl/ex_mem_skid_stage.sv | 195 +++++++++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM elastic boundary: a two-entry (main + skid) valid/ready stage that also
// decodes memory byte lanes, store-data alignment and branch resolution from the main entry.
module ex_mem_skid_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_alu,
  input  logic [XLEN-1:0]        in_rs2,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   in_cmp,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_alu,
  output logic [XLEN-1:0]        out_wdata,
  output logic [XLEN/8-1:0]      out_byte_enable,
  output logic                   out_misaligned,
  output logic                   out_br_en,
  output logic [1:0]             out_pc_sel,
  output logic [XLEN-1:0]        out_pc,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [CNT_W-1:0]       out_stall_cnt
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFS_W = $clog2(BE_W);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   pc;
    logic              cmp;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t            main_q, main_d, skid_q, skid_d, in_entry;
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, fire;

  // Ready depends only on the skid flop, so the cache stall never reaches in_ready combinationally.
  assign in_ready  = ~skid_v_q & ~rst;
  assign out_valid = main_v_q & ~flush;
  assign accept    = in_valid & in_ready & ~flush;
  assign fire      = out_valid & out_ready;

  always_comb begin
    in_entry        = '0;
    in_entry.alu    = in_alu;
    in_entry.rs2    = in_rs2;
    in_entry.pc     = in_pc;
    in_entry.cmp    = in_cmp;
    in_entry.opcode = in_opcode;
    in_entry.funct3 = in_funct3;
    in_entry.ctrl   = in_ctrl;
  end

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (accept) begin
            main_d   = in_entry;
            main_v_d = 1'b1;
          end
        end
        2'b10: begin
          if (accept && fire) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d   = in_entry;
            skid_v_d = 1'b1;
          end else if (fire) begin
            main_v_d = 1'b0;
          end
        end
        2'b11: begin
          if (fire) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          // Unreachable (skid without main); promote the skid entry to recover.
          main_d   = skid_q;
          main_v_d = 1'b1;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  logic [OFS_W-1:0] ofs;
  logic [1:0]       size;
  logic [7:0]       size_mask;
  logic             mis_raw, is_mem;
  logic [BE_W-1:0]  be_mask;

  assign ofs    = main_q.alu[OFS_W-1:0];
  assign size   = main_q.funct3[1:0];
  assign is_mem = (main_q.opcode == OP_LOAD) || (main_q.opcode == OP_STORE);

  always_comb begin
    size_mask = 8'h01;
    mis_raw   = 1'b0;
    case (size)
      2'd0: begin size_mask = 8'h01; mis_raw = 1'b0; end
      2'd1: begin size_mask = 8'h03; mis_raw = ofs[0]; end
      2'd2: begin size_mask = 8'h0F; mis_raw = |ofs[1:0]; end
      default: begin size_mask = 8'hFF; mis_raw = (XLEN == 32) || (|ofs); end
    endcase
    be_mask = BE_W'(size_mask) << ofs;
  end

  always_comb begin
    out_byte_enable = '0;
    out_misaligned  = 1'b0;
    out_br_en       = 1'b0;
    out_pc_sel      = 2'd0;
    out_wdata       = main_q.rs2;
    if (main_q.opcode == OP_STORE) begin
      out_wdata = main_q.rs2 << {ofs, 3'b000};
    end
    if (out_valid) begin
      if (is_mem) begin
        out_misaligned  = mis_raw;
        out_byte_enable = mis_raw ? '0 : be_mask;
      end else begin
        out_byte_enable = '1;
      end
      case (main_q.opcode)
        OP_BR:   begin out_br_en = main_q.cmp; out_pc_sel = main_q.cmp ? 2'd1 : 2'd0; end
        OP_JAL:  begin out_br_en = 1'b1; out_pc_sel = 2'd1; end
        OP_JALR: begin out_br_en = 1'b1; out_pc_sel = 2'd2; end
        default: begin out_br_en = 1'b0; out_pc_sel = 2'd0; end
      endcase
    end
  end

  assign out_alu       = main_q.alu;
  assign out_pc        = main_q.pc;
  assign out_opcode    = main_q.opcode;
  assign out_funct3    = main_q.funct3;
  assign out_ctrl      = main_q.ctrl;
  assign out_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: vector table through a scoreboard plus hand-written
// sequences for skid fill, flush, mid-stream reset and the 64-bit lane decode.
module tb_ex_mem_skid_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cmp, flush, out_valid, out_ready;
  logic [31:0] in_alu, in_rs2, in_pc, out_alu, out_wdata, out_pc;
  logic [6:0]  in_opcode, out_opcode;
  logic [2:0]  in_funct3, out_funct3;
  logic [63:0] in_ctrl, out_ctrl;
  logic [3:0]  out_byte_enable;
  logic        out_misaligned, out_br_en;
  logic [1:0]  out_pc_sel;
  logic [15:0] out_stall_cnt;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_mis, w_br;
  logic [63:0] w_alu, w_rs2, w_out_alu, w_wdata, w_out_pc;
  logic [6:0]  w_opcode, w_out_opcode;
  logic [2:0]  w_funct3, w_out_funct3;
  logic [7:0]  w_be;
  logic [1:0]  w_sel;
  logic [63:0] w_out_ctrl;
  logic [15:0] w_stall;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_rs2(in_rs2), .in_pc(in_pc), .in_cmp(in_cmp),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_ctrl(in_ctrl),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_wdata(out_wdata), .out_byte_enable(out_byte_enable),
    .out_misaligned(out_misaligned), .out_br_en(out_br_en), .out_pc_sel(out_pc_sel),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_ctrl(out_ctrl), .out_stall_cnt(out_stall_cnt)
  );

  ex_mem_skid_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_alu(w_alu), .in_rs2(w_rs2), .in_pc(64'h0), .in_cmp(1'b0),
    .in_opcode(w_opcode), .in_funct3(w_funct3), .in_ctrl(64'h0),
    .flush(1'b0), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_alu(w_out_alu), .out_wdata(w_wdata), .out_byte_enable(w_be),
    .out_misaligned(w_mis), .out_br_en(w_br), .out_pc_sel(w_sel),
    .out_pc(w_out_pc), .out_opcode(w_out_opcode), .out_funct3(w_out_funct3),
    .out_ctrl(w_out_ctrl), .out_stall_cnt(w_stall)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        cmp;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mis;
    logic        br;
    logic [1:0]  sel;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
    logic [63:0] ctrl;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     tag = 0;
  logic [15:0] stall_exp = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] rs2,
                              input logic cmp, input logic [3:0] be, input logic [31:0] wd,
                              input logic mis, input logic br, input logic [1:0] sel);
    vec_t t;
    t.op = op; t.f3 = f3; t.alu = alu; t.rs2 = rs2; t.cmp = cmp;
    t.be = be; t.wd = wd; t.mis = mis; t.br = br; t.sel = sel;
    return t;
  endfunction

  // One clock of stimulus: drive, check at the falling edge, then advance the model.
  task automatic step(input logic v, input vec_t t, input logic rdy, input logic fl, output logic acc);
    logic exp_rdy, exp_ov, fr;
    exp_t item, h;
    item.v    = t;
    item.pc   = 32'h1000 + 32'(tag * 4);
    item.ctrl = {32'hC0DE_0000, 32'(tag)};
    in_valid  = v;      in_alu = t.alu;   in_rs2 = t.rs2;    in_cmp = t.cmp;
    in_opcode = t.op;   in_funct3 = t.f3; in_pc = item.pc;   in_ctrl = item.ctrl;
    out_ready = rdy;    flush = fl;
    @(negedge clk);
    exp_rdy = (sb.size() < 2);
    exp_ov  = (sb.size() > 0) && !fl;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      h = sb[0];
      chk("pc", 64'(out_pc), 64'(h.pc));
      chk("ctrl", out_ctrl, h.ctrl);
      chk("alu", 64'(out_alu), 64'(h.v.alu));
      chk("byte_enable", 64'(out_byte_enable), 64'(h.v.be));
      chk("wdata", 64'(out_wdata), 64'(h.v.wd));
      chk("misaligned", 64'(out_misaligned), 64'(h.v.mis));
      chk("br_en", 64'(out_br_en), 64'(h.v.br));
      chk("pc_sel", 64'(out_pc_sel), 64'(h.v.sel));
    end else begin
      chk("idle_be", 64'(out_byte_enable), 64'h0);
      chk("idle_br_en", 64'(out_br_en), 64'h0);
      chk("idle_pc_sel", 64'(out_pc_sel), 64'h0);
      chk("idle_misaligned", 64'(out_misaligned), 64'h0);
    end
    acc = v && exp_rdy && !fl;
    fr  = exp_ov && rdy;
    if (exp_ov && !rdy && stall_exp != 16'hFFFF) stall_exp++;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (fr) begin
        $display("xfer pc=%08h be=%h wdata=%08h sel=%0d", h.pc, out_byte_enable, out_wdata, out_pc_sel);
        void'(sb.pop_front());
      end
      if (acc) begin
        sb.push_back(item);
        tag++;
      end
    end
    chk("stall_cnt", 64'(out_stall_cnt), 64'(stall_exp));
  endtask

  task automatic send(input vec_t t, input logic random_rdy);
    logic acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      step(1'b1, t, random_rdy ? logic'($urandom_range(0, 1)) : 1'b1, 1'b0, acc);
    end
    if (!acc) chk("send_timeout", 64'h0, 64'h1);
  endtask

  task automatic drain();
    logic acc;
    vec_t idle;
    idle = mk(OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1'b0, idle, 1'b1, 1'b0, acc);
    if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'h0);
  endtask

  vec_t tbl[13];
  vec_t idle_v, va, vb, vc;
  logic acc;
  logic [15:0] s0;

  initial begin
    tbl[0]  = mk(OP_STORE, 3'd0, 32'h0000_0203, 32'h0000_00AB, 1'b0, 4'b1000, 32'hAB00_0000, 1'b0, 1'b0, 2'd0);
    tbl[1]  = mk(OP_STORE, 3'd1, 32'h0000_0302, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_0000, 1'b0, 1'b0, 2'd0);
    tbl[2]  = mk(OP_LOAD,  3'd1, 32'h0000_0401, 32'h0000_0055, 1'b0, 4'b0000, 32'h0000_0055, 1'b1, 1'b0, 2'd0);
    tbl[3]  = mk(OP_LOAD,  3'd3, 32'h0000_0500, 32'h0000_0066, 1'b0, 4'b0000, 32'h0000_0066, 1'b1, 1'b0, 2'd0);
    tbl[4]  = mk(OP_LOAD,  3'd2, 32'h0000_0608, 32'h0000_0077, 1'b0, 4'b1111, 32'h0000_0077, 1'b0, 1'b0, 2'd0);
    tbl[5]  = mk(OP_LOAD,  3'd4, 32'h0000_0702, 32'h0000_0088, 1'b0, 4'b0100, 32'h0000_0088, 1'b0, 1'b0, 2'd0);
    tbl[6]  = mk(OP_STORE, 3'd2, 32'h0000_0802, 32'h0000_BEEF, 1'b0, 4'b0000, 32'hBEEF_0000, 1'b1, 1'b0, 2'd0);
    tbl[7]  = mk(OP_BR,    3'd0, 32'h0000_0900, 32'h0000_0011, 1'b1, 4'b1111, 32'h0000_0011, 1'b0, 1'b1, 2'd1);
    tbl[8]  = mk(OP_BR,    3'd0, 32'h0000_0904, 32'h0000_0022, 1'b0, 4'b1111, 32'h0000_0022, 1'b0, 1'b0, 2'd0);
    tbl[9]  = mk(OP_BR,    3'd1, 32'h0000_0901, 32'h0000_0033, 1'b1, 4'b1111, 32'h0000_0033, 1'b0, 1'b1, 2'd1);
    tbl[10] = mk(OP_JAL,   3'd0, 32'h0000_0A00, 32'h0000_0044, 1'b0, 4'b1111, 32'h0000_0044, 1'b0, 1'b1, 2'd1);
    tbl[11] = mk(OP_JALR,  3'd0, 32'h0000_0B03, 32'h0000_0055, 1'b0, 4'b1111, 32'h0000_0055, 1'b0, 1'b1, 2'd2);
    tbl[12] = mk(OP_ALU,   3'd0, 32'h0000_0C01, 32'h0000_0066, 1'b1, 4'b1111, 32'h0000_0066, 1'b0, 1'b0, 2'd0);
    idle_v  = mk(OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0);

    rst = 1'b1; in_valid = 1'b0; in_alu = '0; in_rs2 = '0; in_pc = '0; in_cmp = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_alu = '0; w_rs2 = '0; w_opcode = '0; w_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_be", 64'(out_byte_enable), 64'h0);
    chk("rst_pc_sel", 64'(out_pc_sel), 64'h0);
    chk("rst_stall", 64'(out_stall_cnt), 64'h0);
    rst = 1'b0;

    // Streaming SW with ready held high: one-cycle latency, no bubbles, no stalls.
    for (int i = 0; i < 8; i++) begin
      va = mk(OP_STORE, 3'd2, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 4'b1111,
              32'hA000_0000 + 32'(i), 1'b0, 1'b0, 2'd0);
      step(1'b1, va, 1'b1, 1'b0, acc);
    end
    drain();
    chk("stream_stall", 64'(out_stall_cnt), 64'h0);

    // Vector table under random back-pressure.
    for (int i = 0; i < 13; i++) send(tbl[i], 1'b1);
    drain();

    // Skid fill: A, B taken with ready low, C held upstream.
    s0 = stall_exp;
    va = tbl[4]; vb = tbl[7]; vc = tbl[11];
    step(1'b1, va, 1'b0, 1'b0, acc);
    step(1'b1, vb, 1'b0, 1'b0, acc);
    chk("skid_full_in_ready", 64'(in_ready), 64'h0);
    step(1'b1, vc, 1'b0, 1'b0, acc);
    step(1'b1, vc, 1'b0, 1'b0, acc);
    chk("skid_stall_delta", 64'(out_stall_cnt - s0), 64'd3);
    send(vc, 1'b0);
    drain();

    // Flush while full with a new input offered and ready low.
    step(1'b1, tbl[0], 1'b0, 1'b0, acc);
    step(1'b1, tbl[1], 1'b0, 1'b0, acc);
    step(1'b1, tbl[9], 1'b0, 1'b1, acc);
    chk("flush_in_ready_next", 64'(in_ready), 64'h1);
    step(1'b0, idle_v, 1'b1, 1'b0, acc);
    step(1'b0, idle_v, 1'b1, 1'b0, acc);

    // Reset asserted mid-stream.
    step(1'b1, tbl[10], 1'b0, 1'b0, acc);
    step(1'b1, tbl[11], 1'b0, 1'b0, acc);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_be", 64'(out_byte_enable), 64'h0);
    chk("midrst_br_en", 64'(out_br_en), 64'h0);
    chk("midrst_pc_sel", 64'(out_pc_sel), 64'h0);
    chk("midrst_alu", 64'(out_alu), 64'h0);
    chk("midrst_stall", 64'(out_stall_cnt), 64'h0);
    rst = 1'b0;
    sb.delete();
    stall_exp = 16'd0;
    step(1'b0, idle_v, 1'b1, 1'b0, acc);
    send(tbl[1], 1'b0);
    drain();

    // 64-bit lane decode.
    chk("x64_in_ready", 64'(w_in_ready), 64'h1);
    w_in_valid = 1'b1; w_opcode = OP_STORE; w_funct3 = 3'd3; w_alu = 64'h8; w_rs2 = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1;
    chk("x64_sd_valid", 64'(w_out_valid), 64'h1);
    chk("x64_sd_be", 64'(w_be), 64'hFF);
    chk("x64_sd_mis", 64'(w_mis), 64'h0);
    chk("x64_sd_wdata", w_wdata, 64'h0123_4567_89AB_CDEF);
    $display("xfer64 sd be=%h", w_be);
    w_funct3 = 3'd2; w_alu = 64'h4; w_rs2 = 64'h0000_0000_DEAD_BEEF;
    @(posedge clk);
    #1;
    chk("x64_sw_be", 64'(w_be), 64'hF0);
    chk("x64_sw_mis", 64'(w_mis), 64'h0);
    chk("x64_sw_wdata", w_wdata, 64'hDEAD_BEEF_0000_0000);
    $display("xfer64 sw be=%h", w_be);
    w_in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
